cpu_mem: RTL and testbench
==========================

# cpu_mem

Unified 256x8 instruction/data memory for the 8-bit CPU, answering the CPU's `address`/`store`/`out_data` bus and returning the fetched byte on `inst`. A byte-stream load port fills the memory while the block holds the CPU in reset. On completion, the block primes the first fetch and releases the CPU. During run, CPU stores are written back and counted.

## Interface
- `DATA_W`, 8, memory word and bus width
- `ADDR_W`, 8, address width; depth is 2**ADDR_W = 256
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `address`  in  ADDR_W  CPU fetch/store address
- `store`  in  1  CPU write strobe
- `out_data`  in  DATA_W  CPU write data
- `inst`  out  DATA_W  registered read data to CPU instruction register
- `cpu_reset`  out  1  active-low reset to CPU; low while not in RUN
- `load_start`  in  1  one-cycle request to (re)enter LOAD
- `load_valid`  in  1  loader byte valid
- `load_data`  in  DATA_W  loader byte
- `load_last`  in  1  marks final byte; qualified by `load_valid`
- `load_ready`  out  1  block accepts a byte this cycle
- `store_count`  out  8  number of CPU stores since last LOAD entry, saturating at 255

## Operation
- States: LOAD, PRIME, RUN. Reset (`reset`=0) -> LOAD.
  - Reset clears `ptr`=0, `inst`=8'h00, and `store_count`=0.
  - Memory array contents are not reset.
- LOAD:
  - `load_ready`=1 and `cpu_reset`=0.
  - A transfer occurs when `load_valid` && `load_ready`. It writes `load_data` to mem[`ptr`] and increments `ptr` mod 256; byte 256 wraps to address 0 and overwrites it.
  - A transfer with `load_last`=1 -> PRIME.
  - `store` is ignored.
  - `load_start` in LOAD restarts: `ptr`<=0, and any transfer in the same cycle is dropped.
- PRIME (exactly one cycle):
  - `load_ready`=0, `cpu_reset`=0.
  - `inst` <= mem[0] (the byte just written if `ptr` wrapped) -> RUN.
- RUN:
  - `cpu_reset`=1, `load_ready`=0.
  - Every cycle `inst` <= mem[`address`].
  - If `store`=1: mem[`address`] <= `out_data`, and `store_count` increments, saturating at 255.
- Same-address read/write in RUN is read-before-write: `inst` gets the old byte and the new byte is visible from the next cycle.
- `load_start`=1 in RUN or PRIME:
  - Next state LOAD, `ptr`<=0, `store_count`<=0.
  - A `store` in that same cycle is still written.
  - `cpu_reset` goes low on the next cycle.
- `load_valid` outside LOAD is ignored; no data is lost because `load_ready`=0.

## Timing
- `inst` latency: 1 cycle from `address`. This matches the CPU presenting the next PC on `address` while its IR captures `inst`.
- First CPU cycle after release: `cpu_reset` rises on the same edge that the PRIME state's `inst`=mem[0] becomes visible.
- Load throughput: 1 byte/cycle, with no back-pressure inside LOAD.
- Transition timing:
  - Last load byte at edge N -> PRIME during cycle N+1 -> RUN with `cpu_reset`=1 from edge N+2.
  - `load_start` sampled at edge N -> LOAD, with `cpu_reset`=0, from edge N+1.
- Reset mid-load or mid-run: the next edge enters LOAD with outputs at their reset values. Memory keeps its partial contents.
- Reset values: `inst`=8'h00, `cpu_reset`=0, `load_ready`=1 (LOAD), `store_count`=0.

## Structure
- Shared package holds:
  - the state encoding typedef (LOAD, PRIME, RUN)
  - `DATA_W`/`ADDR_W` defaults
  - the `store_count` saturation constant 8'hFF
- One natural sub-module: `mem_array`, 256xDATA_W synchronous single-port RAM.
  - One write port, muxed between loader and CPU by state.
  - One registered read port with read-before-write behaviour.
- The FSM, pointer, counter and muxing live in `cpu_mem`.

## Test plan
- Reset, then load 4 bytes 8'h11,22,33,44, with `load_last` on 8'h44:
  - `load_ready` drops on the cycle after the last byte.
  - PRIME lasts 1 cycle with `inst`=8'h11.
  - `cpu_reset`=1 two edges after the last byte.
- RUN with `address`=2 then 3 -> `inst`=8'h33 then 8'h44, each one cycle later.
- RUN, `store`=1, `address`=8'h05, `out_data`=8'hA5, while reading addr 5 -> `inst`=old value that cycle, 8'hA5 next cycle, `store_count`=1.
- 300 consecutive stores -> `store_count` saturates at 8'hFF.
- `load_start` in RUN -> `cpu_reset`=0 next cycle and `store_count`=0. Load 257 bytes where byte 256 = 8'hEE -> PRIME gives `inst`=8'hEE (address 0 wrapped).
- Assert `reset` low mid-load after 2 bytes, then reload 1 byte 8'h77 with `load_last` -> `inst`=8'h77 in PRIME. Byte at addr 1 retains its pre-reset value.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified CPU instruction/data memory.
// Imported by cpu_mem and its mem_array sub-module.
package cpu_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    localparam logic [7:0] STORE_COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_mem_mem_array.sv
// Synchronous single-port RAM with a registered, read-before-write read port.
// The read register clears on reset; the array itself is never reset.
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Reading and writing in the same block returns the old byte on a collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_mem.sv
// Unified 256x8 CPU memory: loads a byte stream while holding the CPU in reset,
// primes the first fetch from address 0, then serves CPU fetches and stores.
module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              store,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] inst,
    output logic              cpu_reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [7:0]        store_count
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    logic              load_xfer;
    logic              mem_we;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // A restart request in LOAD wins over a byte offered in the same cycle.
    assign load_xfer = (state == ST_LOAD) && load_valid && !load_start;

    // The single RAM port belongs to the loader in LOAD and to the CPU in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = address;
        mem_wdata = out_data;
        case (state)
            ST_LOAD: begin
                mem_we    = reset && load_xfer;
                mem_addr  = ptr;
                mem_wdata = load_data;
            end
            ST_PRIME: begin
                mem_rd_en = 1'b1;
                mem_addr  = '0;
            end
            ST_RUN: begin
                mem_we    = reset && store;
                mem_rd_en = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .rd_en (mem_rd_en),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (inst)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_LOAD;
            ptr         <= '0;
            store_count <= '0;
            cpu_reset   <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_start) begin
                        ptr <= '0;
                    end else if (load_valid) begin
                        ptr <= ptr + 1'b1;
                        if (load_last) begin
                            state      <= ST_PRIME;
                            load_ready <= 1'b0;
                        end
                    end
                end
                ST_PRIME: begin
                    if (load_start) begin
                        state       <= ST_LOAD;
                        ptr         <= '0;
                        store_count <= '0;
                        load_ready  <= 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state       <= ST_LOAD;
                        ptr         <= '0;
                        store_count <= '0;
                        cpu_reset   <= 1'b0;
                        load_ready  <= 1'b1;
                    end else if (store && (store_count != STORE_COUNT_MAX)) begin
                        store_count <= store_count + 8'd1;
                    end
                end
                default: begin
                    state      <= ST_LOAD;
                    ptr        <= '0;
                    cpu_reset  <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem.sv
// Self-checking bench for cpu_mem: directed test-plan steps mixed with random
// traffic, compared against a cycle-level behavioural model of the memory.
module tb_cpu_mem;

    localparam int M_LOAD  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic       store;
    logic [7:0] out_data;
    logic [7:0] inst;
    logic       cpu_reset;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic [7:0] store_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem   [256];
    bit         ref_known [256];
    int         mode;
    int         m_ptr;
    int         m_count;
    logic [7:0] m_inst;
    bit         m_inst_known;

    always #5 clk = ~clk;

    cpu_mem dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .store       (store),
        .out_data    (out_data),
        .inst        (inst),
        .cpu_reset   (cpu_reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .store_count (store_count)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".load_ready"}, {7'd0, load_ready}, {7'd0, mode == M_LOAD});
        check({tag, ".cpu_reset"}, {7'd0, cpu_reset}, {7'd0, mode == M_RUN});
        check({tag, ".store_count"}, store_count, 8'(m_count));
        if (m_inst_known) begin
            check({tag, ".inst"}, inst, m_inst);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven, then
    // let the DUT take the same edge and settle to the falling edge.
    task automatic clock_step();
        if (!reset) begin
            mode         = M_LOAD;
            m_ptr        = 0;
            m_count      = 0;
            m_inst       = 8'h00;
            m_inst_known = 1'b1;
        end else if (mode == M_LOAD) begin
            if (load_start) begin
                m_ptr = 0;
            end else if (load_valid) begin
                ref_mem[m_ptr]   = load_data;
                ref_known[m_ptr] = 1'b1;
                m_ptr            = (m_ptr + 1) % 256;
                if (load_last) mode = M_PRIME;
            end
        end else if (mode == M_PRIME) begin
            m_inst       = ref_mem[0];
            m_inst_known = ref_known[0];
            if (load_start) begin
                mode    = M_LOAD;
                m_ptr   = 0;
                m_count = 0;
            end else begin
                mode = M_RUN;
            end
        end else begin
            m_inst       = ref_mem[int'(address)];
            m_inst_known = ref_known[int'(address)];
            if (store) begin
                ref_mem[int'(address)]   = out_data;
                ref_known[int'(address)] = 1'b1;
                m_count = (m_count < 255) ? m_count + 1 : 255;
            end
            if (load_start) begin
                mode    = M_LOAD;
                m_ptr   = 0;
                m_count = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input string tag);
        clock_step();
        check_output(tag);
    endtask

    task automatic load_byte(input logic [7:0] data, input logic last, input string tag);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        apply_stimulus(tag);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'h00;
            ref_known[i] = 1'b0;
        end
        mode         = M_LOAD;
        m_ptr        = 0;
        m_count      = 0;
        m_inst       = 8'h00;
        m_inst_known = 1'b0;

        reset      = 1'b0;
        address    = 8'h00;
        store      = 1'b0;
        out_data   = 8'h00;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        @(negedge clk);
        apply_stimulus("reset");
        check("reset.inst_const", inst, 8'h00);
        check("reset.ready_const", {7'd0, load_ready}, 8'h01);
        reset = 1'b1;

        // Basic four-byte program.
        load_byte(8'h11, 1'b0, "load0");
        load_byte(8'h22, 1'b0, "load1");
        load_byte(8'h33, 1'b0, "load2");
        load_byte(8'h44, 1'b1, "load3");
        check("prime.ready_low", {7'd0, load_ready}, 8'h00);
        check("prime.cpu_reset_low", {7'd0, cpu_reset}, 8'h00);
        apply_stimulus("prime");
        check("release.inst", inst, 8'h11);
        check("release.cpu_reset", {7'd0, cpu_reset}, 8'h01);

        address = 8'd2;
        apply_stimulus("run_addr2");
        check("run_addr2.inst_const", inst, 8'h33);
        address = 8'd3;
        apply_stimulus("run_addr3");
        check("run_addr3.inst_const", inst, 8'h44);

        // Same-address store: first seed a known value, then overwrite it.
        address  = 8'h05;
        store    = 1'b1;
        out_data = 8'h5A;
        apply_stimulus("seed5");
        out_data = 8'hA5;
        apply_stimulus("rbw5");
        check("rbw5.old", inst, 8'h5A);
        check("rbw5.count", store_count, 8'd2);
        store = 1'b0;
        apply_stimulus("rbw5_next");
        check("rbw5_next.new", inst, 8'hA5);

        // Random CPU traffic; stray loader activity must be ignored.
        for (int i = 0; i < 120; i++) begin
            address    = 8'($urandom);
            store      = ($urandom_range(0, 2) == 0);
            out_data   = 8'($urandom);
            load_valid = $urandom_range(0, 1) == 1;
            load_data  = 8'($urandom);
            apply_stimulus("run_rand");
        end
        load_valid = 1'b0;

        store = 1'b1;
        for (int i = 0; i < 300; i++) begin
            address  = 8'($urandom);
            out_data = 8'($urandom);
            apply_stimulus("sat");
        end
        check("sat.count_const", store_count, 8'hFF);

        // Restart from RUN with a store in the same cycle.
        address    = 8'h09;
        out_data   = 8'h3C;
        load_start = 1'b1;
        apply_stimulus("restart");
        load_start = 1'b0;
        store      = 1'b0;
        check("restart.cpu_reset", {7'd0, cpu_reset}, 8'h00);
        check("restart.count", store_count, 8'h00);

        // Restart inside LOAD drops the byte offered alongside it.
        load_byte(8'h99, 1'b0, "pre_restart");
        load_start = 1'b1;
        load_byte(8'h98, 1'b0, "load_restart");
        load_start = 1'b0;

        // 257 bytes with random gaps; the last one wraps onto address 0.
        for (int i = 0; i < 257; i++) begin
            while ($urandom_range(0, 3) == 0) apply_stimulus("load_gap");
            load_byte((i == 256) ? 8'hEE : 8'($urandom), i == 256, "load257");
        end
        apply_stimulus("prime_wrap");
        check("prime_wrap.inst", inst, 8'hEE);

        for (int i = 0; i < 60; i++) begin
            address  = 8'($urandom);
            store    = $urandom_range(0, 1) == 1;
            out_data = 8'($urandom);
            apply_stimulus("run_rand2");
        end
        store = 1'b0;

        // Reset in the middle of a reload.
        load_start = 1'b1;
        apply_stimulus("restart2");
        load_start = 1'b0;
        load_byte(8'hC0, 1'b0, "part0");
        load_byte(8'hC1, 1'b0, "part1");
        reset = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hDD;
        apply_stimulus("mid_reset");
        load_valid = 1'b0;
        check("mid_reset.inst", inst, 8'h00);
        reset = 1'b1;
        load_byte(8'h77, 1'b1, "reload");
        apply_stimulus("prime77");
        check("prime77.inst", inst, 8'h77);
        address = 8'h01;
        apply_stimulus("keep1");
        check("keep1.inst", inst, 8'hC1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
